// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for the 8-bit combinational ALU: buffers commands in a FIFO,
// issues registered operands, waits a settle time, captures the result and supports chaining.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_chain,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] CNT_INIT   = TW'(SETTLE - 1);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] cnt;
  logic [7:0]    acc;
  cmd_t          head;
  logic          push;
  logic          pop;
  logic          load_res;

  // cmd_ready comes from the registered count only, keeping input handshakes free of comb paths
  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_chain};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_res  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // a held, unconsumed result blocks capture; operands stay put meanwhile
        if (!res_valid || res_ready) begin
          load_res  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cnt       <= '0;
      acc       <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      if (pop) begin
        alu_sel <= head.op;
        alu_b   <= head.b;
        alu_a   <= head.chain ? acc : head.a;
        cnt     <= CNT_INIT;
      end else if (state == ST_SETTLE && cnt != '0) begin
        cnt <= cnt - TW'(1);
      end
      // a same-edge consume and load keeps res_valid high with the new data
      if (load_res) begin
        res_data  <= alu_result;
        acc       <= alu_result;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed test-plan steps plus randomized traffic checked
// against a push-order result model with a behavioural ALU.
module tb_alu_op_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int SETTLE     = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  int         consumed = 0;
  logic [7:0] expq[$];
  logic [7:0] model_acc;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .SETTLE    (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_chain (cmd_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  // Stand-in for the team ALU
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a + (b << 1);
      3'd3:    return a ^ b;
      3'd4:    return {4'b0, a[3:0]} * {4'b0, b[3:0]};
      3'd5:    return a & b;
      3'd6:    return a[7] ? (8'd0 - a) : a;
      default: return a | b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: score any result handshake, record any accepted command, then advance
  task automatic tick();
    logic [7:0] a_eff;
    logic [7:0] r;
    if (res_valid && res_ready) begin
      consumed++;
      if (expq.size() == 0) checkOutput("res_extra", 32'(res_valid), 32'd0);
      else checkOutput("res_data", 32'(res_data), 32'(expq.pop_front()));
    end
    if (cmd_valid && cmd_ready) begin
      a_eff     = cmd_chain ? model_acc : cmd_a;
      r         = alu_fn(cmd_op, a_eff, cmd_b);
      model_acc = r;
      expq.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic chain);
    bit accepted = 0;
    int n = 0;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    cmd_valid = 1'b1;
    while (!accepted && n < 100) begin
      accepted = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!accepted) checkOutput("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic waitResult(input string tag, input logic [7:0] expected);
    int n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(res_valid), 32'd1);
    checkOutput(tag, 32'(res_data), 32'(expected));
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    while ((expq.size() != 0 || res_valid || busy) && n < 500) begin
      tick();
      n++;
    end
    checkOutput("drain_leftover", 32'(expq.size()), 32'd0);
    checkOutput("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    checkOutput({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    checkOutput({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    checkOutput({tag, "_res_data"}, 32'(res_data), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Command pushed in cycle 0 into an idle, empty sequencer; result expected in cycle 4
  task automatic singleOp();
    res_ready = 1'b1;
    cmd_op    = 3'd0;
    cmd_a     = 8'h10;
    cmd_b     = 8'h05;
    cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    checkOutput("lat_c0_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    checkOutput("lat_c1_valid", 32'(res_valid), 32'd0);
    tick();
    checkOutput("lat_c2_alu_a", 32'(alu_a), 32'h10);
    checkOutput("lat_c2_alu_b", 32'(alu_b), 32'h05);
    tick();
    checkOutput("lat_c3_valid", 32'(res_valid), 32'd0);
    checkOutput("lat_c3_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("lat_c4_valid", 32'(res_valid), 32'd1);
    checkOutput("lat_c4_data", 32'(res_data), 32'h15);
    checkOutput("lat_c4_busy", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_chain = 1'b0;
    res_ready = 1'b0;
    model_acc = '0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    singleOp();

    applyStimulus(3'd2, 8'h00, 8'h03, 1'b1);
    tick();
    checkOutput("chain_alu_a", 32'(alu_a), 32'h15);
    waitResult("chain_res", 8'h1B);
    applyStimulus(3'd1, 8'h00, 8'h20, 1'b1);
    waitResult("chain_wrap", 8'hFB);
    applyStimulus(3'd6, 8'hF6, 8'h00, 1'b0);
    waitResult("abs", 8'h0A);
    applyStimulus(3'd4, 8'h3C, 8'h2D, 1'b0);
    waitResult("mult", 8'h9C);
    drain();

    // Backpressure: six back-to-back commands while the consumer is stalled
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    repeat (6) tick();
    checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
    if (expq.size() != 0) checkOutput("bp_res_hold", 32'(res_data), 32'(expq[0]));
    consumed = 0;
    drain();
    checkOutput("bp_delivered", 32'(consumed), 32'd6);

    // Consume and load on the same edge
    res_ready = 1'b0;
    applyStimulus(3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    applyStimulus(3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    repeat (8) tick();
    checkOutput("sim_pre_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    checkOutput("sim_valid", 32'(res_valid), 32'd1);
    if (expq.size() != 0) checkOutput("sim_data", 32'(res_data), 32'(expq[0]));
    drain();

    // Reset while SETTLE with two commands queued
    res_ready = 1'b1;
    applyStimulus(3'd0, 8'h01, 8'h02, 1'b0);
    applyStimulus(3'd3, 8'h5A, 8'hA5, 1'b0);
    applyStimulus(3'd5, 8'hF0, 8'h3C, 1'b0);
    applyStimulus(3'd7, 8'h11, 8'h22, 1'b0);
    tick();
    checkOutput("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    expq.delete();
    model_acc = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (5) begin
      checkOutput("post_rst_valid", 32'(res_valid), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      tick();
    end
    applyStimulus(3'd0, 8'h77, 8'h05, 1'b1);
    waitResult("post_rst_chain_acc0", 8'h05);
    drain();
    singleOp();
    drain();

    // Randomized traffic with random gaps and backpressure
    for (int i = 0; i < 300; i++) begin
      cmd_op    = 3'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_chain = 1'($urandom);
      cmd_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    cmd_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
